// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the load-store path.
// Owns a word-addressed RAM, applies byte-lane store masking, sign/zero
// extends loads, inserts programmable wait states and flags access faults.
// One request outstanding at a time; every completed access answers with a
// single-cycle rsp_valid strobe.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        start,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_memaccess,
  input  logic [2:0]  req_mask_mode,
  input  logic        req_abort,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES  = 32'(4 * DEPTH_WORDS);
  localparam logic        NO_WAIT     = (WAIT_STATES == 0);
  localparam logic [3:0]  WS_CNT_INIT = 4'((WAIT_STATES == 0) ? 0 : (WAIT_STATES - 1));

  localparam logic [1:0] MA_NONE  = 2'b00;
  localparam logic [1:0] MA_READ  = 2'b01;
  localparam logic [1:0] MA_WRITE = 2'b10;
  localparam logic [1:0] MA_ILL   = 2'b11;

  localparam logic [2:0] MM_B  = 3'b000;
  localparam logic [2:0] MM_H  = 3'b001;
  localparam logic [2:0] MM_W  = 3'b010;
  localparam logic [2:0] MM_BU = 3'b100;
  localparam logic [2:0] MM_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Fault decision for a request; off is the address relative to BASE_ADDR,
  // so addresses below the window wrap to huge offsets and fault as well.
  function automatic logic access_fault(input logic [1:0] ma, input logic [2:0] mm,
                                        input logic [1:0] addr_lo, input logic [31:0] off);
    logic mode_bad;
    logic align_bad;
    mode_bad  = 1'b0;
    align_bad = 1'b0;
    case (mm)
      MM_B, MM_BU: align_bad = 1'b0;
      MM_H, MM_HU: align_bad = addr_lo[0];
      MM_W:        align_bad = (addr_lo != 2'b00);
      default:     mode_bad  = 1'b1;
    endcase
    return (ma == MA_ILL) | mode_bad | align_bad | (off >= SPAN_BYTES) |
           ((ma == MA_WRITE) & ((mm == MM_BU) | (mm == MM_HU)));
  endfunction

  // Select the addressed lane(s) of a RAM word and extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [2:0] mm);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    byte_v = 8'(word >> {lane, 3'b000});
    half_v = 16'(word >> {lane[1], 4'b0000});
    case (mm)
      MM_B:    res = {{24{byte_v[7]}}, byte_v};
      MM_BU:   res = {24'h00_0000, byte_v};
      MM_H:    res = {{16{half_v[15]}}, half_v};
      MM_HU:   res = {16'h0000, half_v};
      MM_W:    res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Merge right-aligned store data into the old word; unwritten lanes keep old bytes.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] lane, input logic [2:0] mm);
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] res;
    case (mm)
      MM_B, MM_BU: begin be = 4'b0001 << lane;            data = {4{wd[7:0]}};  end
      MM_H, MM_HU: begin be = 4'b0011 << {lane[1], 1'b0}; data = {2{wd[15:0]}}; end
      MM_W:        begin be = 4'b1111;                    data = wd;            end
      default:     begin be = 4'b0000;                    data = wd;            end
    endcase
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? data[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

  state_t      state_r, state_next_s;
  logic [31:0] addr_r, wdata_r;
  logic [1:0]  ma_r;
  logic [2:0]  mm_r;
  logic [3:0]  cnt_r;
  logic        rsp_valid_r, rsp_fault_r;
  logic [31:0] rsp_rdata_r;
  logic [31:0] mem_r [DEPTH_WORDS];

  logic [31:0] op_addr_s, op_wdata_s, op_off_s, rd_word_s;
  logic [1:0]  op_ma_s, lane_s;
  logic [2:0]  op_mm_s;
  logic [AW-1:0] idx_s;
  logic        req_ready_s, accept_s, fault_s;
  logic        enter_resp_s, resp_fault_s, load_cnt_s, commit_s;

  // Operands come straight from the request in IDLE (fault check, zero-wait
  // commit) and from the captured copy while waiting.
  always_comb begin
    op_addr_s  = addr_r;
    op_wdata_s = wdata_r;
    op_ma_s    = ma_r;
    op_mm_s    = mm_r;
    if (state_r == ST_IDLE) begin
      op_addr_s  = req_addr;
      op_wdata_s = req_wdata;
      op_ma_s    = req_memaccess;
      op_mm_s    = req_mask_mode;
    end else begin
      op_addr_s  = addr_r;
      op_wdata_s = wdata_r;
      op_ma_s    = ma_r;
      op_mm_s    = mm_r;
    end
  end

  assign op_off_s    = op_addr_s - BASE_ADDR;
  assign idx_s       = op_off_s[AW+1:2];
  assign lane_s      = op_off_s[1:0];
  assign rd_word_s   = mem_r[idx_s];
  assign fault_s     = access_fault(op_ma_s, op_mm_s, op_addr_s[1:0], op_off_s);
  assign req_ready_s = (state_r == ST_IDLE) & start;
  assign accept_s    = req_valid & req_ready_s & (req_memaccess != MA_NONE) & ~req_abort;
  assign commit_s    = enter_resp_s & ~resp_fault_s;

  // Next-state logic; also flags the edge that enters RESP and whether it is a fault.
  always_comb begin
    state_next_s = state_r;
    enter_resp_s = 1'b0;
    resp_fault_s = 1'b0;
    load_cnt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (fault_s) begin
            state_next_s = ST_RESP;
            enter_resp_s = 1'b1;
            resp_fault_s = 1'b1;
          end else if (NO_WAIT) begin
            state_next_s = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_next_s = ST_WAIT;
            load_cnt_s   = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (req_abort) begin
          state_next_s = ST_IDLE;
        end else if (cnt_r == 4'd0) begin
          state_next_s = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture the accepted request for use during the wait states.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      ma_r    <= 2'b00;
      mm_r    <= 3'b000;
    end else if (accept_s) begin
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      ma_r    <= req_memaccess;
      mm_r    <= req_mask_mode;
    end
  end

  // Wait-state counter: loaded on a non-faulting accept, counts down in WAIT.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      cnt_r <= 4'd0;
    end else if (load_cnt_s) begin
      cnt_r <= WS_CNT_INIT;
    end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Response registers: strobe for one cycle, data/fault hold between responses.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      rsp_valid_r <= 1'b0;
      rsp_fault_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end else begin
      rsp_valid_r <= enter_resp_s;
      if (enter_resp_s) begin
        rsp_fault_r <= resp_fault_s;
        rsp_rdata_r <= (commit_s && (op_ma_s == MA_READ)) ?
                       load_extend(rd_word_s, lane_s, op_mm_s) : 32'h0000_0000;
      end
    end
  end

  // Data RAM: the store commits on the edge that enters RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_s && (op_ma_s == MA_WRITE)) begin
      mem_r[idx_s] <= store_merge(rd_word_s, op_wdata_s, lane_s, op_mm_s);
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_fault = rsp_fault_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder. dut_a uses one wait
// state, dut_b zero wait states; both share the request inputs.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        start;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_memaccess;
  logic [2:0]  req_mask_mode;
  logic        req_abort;
  logic        ready_a, valid_a, fault_a;
  logic [31:0] rdata_a;
  logic        ready_b, valid_b, fault_b;
  logic [31:0] rdata_b;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] RD = 2'b01, WR = 2'b10;
  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  always #5 clk = ~clk;

  dmem_responder #(.BASE_ADDR(32'h1000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(1)) dut_a (
    .clk(clk), .start(start), .req_valid(req_valid), .req_ready(ready_a),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_memaccess(req_memaccess),
    .req_mask_mode(req_mask_mode), .req_abort(req_abort),
    .rsp_valid(valid_a), .rsp_rdata(rdata_a), .rsp_fault(fault_a));

  dmem_responder #(.BASE_ADDR(32'h1000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_b (
    .clk(clk), .start(start), .req_valid(req_valid), .req_ready(ready_b),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_memaccess(req_memaccess),
    .req_mask_mode(req_mask_mode), .req_abort(req_abort),
    .rsp_valid(valid_b), .rsp_rdata(rdata_b), .rsp_fault(fault_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on dut_a: checks ready, latency, fault, data and pulse width.
  task automatic txn(input string tag, input logic [1:0] acc, input logic [2:0] mm,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int exp_lat, input logic exp_fault, input logic [31:0] exp_rd);
    int n;
    check({tag, ".ready"}, {31'b0, ready_a}, 32'd1);
    req_valid = 1'b1; req_memaccess = acc; req_mask_mode = mm;
    req_addr = addr; req_wdata = wd;
    tick();
    req_valid = 1'b0; req_memaccess = 2'b00;
    n = 0;
    while (!valid_a && n < 8) begin
      tick();
      n++;
    end
    check({tag, ".lat"},   32'(n), 32'(exp_lat));
    check({tag, ".fault"}, {31'b0, fault_a}, {31'b0, exp_fault});
    check({tag, ".rdata"}, rdata_a, exp_rd);
    check({tag, ".rsp_rdy"}, {31'b0, ready_a}, 32'd0);
    tick();
    check({tag, ".pulse"}, {31'b0, valid_a}, 32'd0);
  endtask

  initial begin
    start = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_memaccess = 2'b00; req_mask_mode = 3'b000; req_abort = 1'b0;
    tick(); tick();
    check("rst.ready", {31'b0, ready_a}, 32'd0);
    check("rst.valid", {31'b0, valid_a}, 32'd0);
    check("rst.rdata", rdata_a, 32'h0);
    check("rst.fault", {31'b0, fault_a}, 32'd0);
    start = 1'b1;
    #1;
    check("rst.release", {31'b0, ready_a}, 32'd1);

    // Basic word store/load and byte/half lanes with extension.
    txn("sw10",  WR, W,  32'h1000_0010, 32'hDEAD_BEEF, 1, 1'b0, 32'h0);
    txn("lw10",  RD, W,  32'h1000_0010, 32'h0,         1, 1'b0, 32'hDEAD_BEEF);
    txn("sb13",  WR, B,  32'h1000_0013, 32'h0000_0080, 1, 1'b0, 32'h0);
    txn("lb13",  RD, B,  32'h1000_0013, 32'h0,         1, 1'b0, 32'hFFFF_FF80);
    txn("lbu13", RD, BU, 32'h1000_0013, 32'h0,         1, 1'b0, 32'h0000_0080);
    txn("lw10b", RD, W,  32'h1000_0010, 32'h0,         1, 1'b0, 32'h80AD_BEEF);
    txn("lh12",  RD, H,  32'h1000_0012, 32'h0,         1, 1'b0, 32'hFFFF_80AD);
    txn("lhu12", RD, HU, 32'h1000_0012, 32'h0,         1, 1'b0, 32'h0000_80AD);
    txn("sh10",  WR, H,  32'h1000_0010, 32'hFFFF_1234, 1, 1'b0, 32'h0);
    txn("lw10c", RD, W,  32'h1000_0010, 32'h0,         1, 1'b0, 32'h80AD_1234);
    txn("swffc", WR, W,  32'h1000_0FFC, 32'hCAFE_F00D, 1, 1'b0, 32'h0);

    // Faults: one-cycle latency, zero data, no RAM effect.
    txn("f.lwmis", RD, W,      32'h1000_0012, 32'h0,         0, 1'b1, 32'h0);
    txn("f.lhmis", RD, H,      32'h1000_0011, 32'h0,         0, 1'b1, 32'h0);
    txn("f.range", WR, W,      32'h1000_1000, 32'h5555_5555, 0, 1'b1, 32'h0);
    txn("f.mode3", RD, 3'b011, 32'h1000_0010, 32'h0,         0, 1'b1, 32'h0);
    txn("f.sbu",   WR, BU,     32'h1000_0010, 32'h0000_00FF, 0, 1'b1, 32'h0);
    txn("f.below", RD, W,      32'h0FFF_FFFC, 32'h0,         0, 1'b1, 32'h0);
    txn("f.ma11",  2'b11, W,   32'h1000_0010, 32'h0,         0, 1'b1, 32'h0);
    txn("lwffc",   RD, W,      32'h1000_0FFC, 32'h0,         1, 1'b0, 32'hCAFE_F00D);
    txn("lbffe",   RD, B,      32'h1000_0FFE, 32'h0,         1, 1'b0, 32'hFFFF_FFFE);
    txn("lw10d",   RD, W,      32'h1000_0010, 32'h0,         1, 1'b0, 32'h80AD_1234);
    txn("sw20",    WR, W,      32'h1000_0020, 32'h1111_2222, 1, 1'b0, 32'h0);

    // memaccess=00 is ignored; abort at the accept edge blocks acceptance.
    req_valid = 1'b1; req_memaccess = 2'b00; req_mask_mode = W;
    req_addr = 32'h1000_0020; req_wdata = 32'h1234_5678;
    tick();
    check("ma00.ready", {31'b0, ready_a}, 32'd1);
    check("ma00.valid", {31'b0, valid_a}, 32'd0);
    req_memaccess = WR; req_abort = 1'b1;
    tick();
    check("abidle.ready", {31'b0, ready_a}, 32'd1);
    tick();
    check("abidle.valid", {31'b0, valid_a}, 32'd0);
    // Abort while waiting: back to IDLE with no response and no write.
    req_abort = 1'b0;
    tick();
    check("abwait.acc", {31'b0, ready_a}, 32'd0);
    req_valid = 1'b0; req_memaccess = 2'b00; req_abort = 1'b1;
    tick();
    check("abwait.valid", {31'b0, valid_a}, 32'd0);
    check("abwait.ready", {31'b0, ready_a}, 32'd1);
    req_abort = 1'b0;
    tick();
    check("abwait.valid2", {31'b0, valid_a}, 32'd0);
    txn("lw20a", RD, W, 32'h1000_0020, 32'h0, 1, 1'b0, 32'h1111_2222);

    // Asynchronous reset while in WAIT of a store.
    req_valid = 1'b1; req_memaccess = WR; req_mask_mode = W;
    req_addr = 32'h1000_0020; req_wdata = 32'hAAAA_5555;
    tick();
    req_valid = 1'b0; req_memaccess = 2'b00;
    #2 start = 1'b0;
    #1;
    check("arst.ready", {31'b0, ready_a}, 32'd0);
    check("arst.valid", {31'b0, valid_a}, 32'd0);
    check("arst.rdata", rdata_a, 32'h0);
    check("arst.fault", {31'b0, fault_a}, 32'd0);
    tick();
    start = 1'b1;
    #1;
    check("arst.ready1", {31'b0, ready_a}, 32'd1);
    txn("lw20b", RD, W, 32'h1000_0020, 32'h0, 1, 1'b0, 32'h1111_2222);

    // Zero wait states, request held: accept every second cycle.
    req_valid = 1'b1; req_memaccess = RD; req_mask_mode = W;
    req_addr = 32'h1000_0010; req_wdata = 32'h0;
    check("ws0.ready0", {31'b0, ready_b}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("ws0.valid%0d", i), {31'b0, valid_b}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("ws0.ready%0d", i), {31'b0, ready_b}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 0) begin
        check($sformatf("ws0.rdata%0d", i), rdata_b, 32'h80AD_1234);
        check($sformatf("ws0.fault%0d", i), {31'b0, fault_b}, 32'd0);
      end
    end
    req_valid = 1'b0; req_memaccess = 2'b00;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
